// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch/memory-stage) arbiter onto one SRAM-like slave port, one transaction in flight.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module sram_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  output logic              busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_data_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;   // 0 = inst, 1 = data
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        starve_q, starve_d;

  logic grant_data, grant_inst, idle, done, in_data;

  // Data has priority unless fetch has already been passed over STARVE_MAX times.
  assign grant_data = data_req && !(inst_req && (starve_q == STARVE_LIM));
  assign grant_inst = inst_req && !grant_data;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (grant_data || grant_inst) begin
          state_d = ADDR;
          owner_d = grant_data;
          wr_d    = grant_data ? data_wr    : inst_wr;
          size_d  = grant_data ? data_size  : inst_size;
          addr_d  = grant_data ? data_addr  : inst_addr;
          wdata_d = grant_data ? data_wdata : inst_wdata;
          if (grant_data && inst_req)
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
          else
            starve_d = '0;
        end
      end
      ADDR:    if (s_addr_ok) state_d = DATA;
      DATA:    if (s_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Every output is forced low while rst is high so a reset cycle never leaks a handshake.
  assign idle    = (state_q == IDLE) && !rst;
  assign in_data = (state_q == DATA) && !rst;
  assign done    = in_data && s_data_ok;

  assign inst_addr_ok = idle && grant_inst;
  assign data_addr_ok = idle && grant_data;
  assign inst_data_ok = done && !owner_q;
  assign data_data_ok = done && owner_q;
  assign inst_rdata   = (in_data && !owner_q) ? s_rdata : '0;
  assign data_rdata   = (in_data && owner_q)  ? s_rdata : '0;

  assign s_req   = (state_q == ADDR) && !rst;
  assign s_wr    = rst ? 1'b0 : wr_q;
  assign s_size  = rst ? '0   : size_q;
  assign s_addr  = rst ? '0   : addr_q;
  assign s_wdata = rst ? '0   : wdata_q;
  assign busy    = (state_q != IDLE) && !rst;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_q, perf_data_q, perf_wait_q;
  logic [31:0] wait_inc;

  assign wait_inc = 32'(inst_req && !inst_addr_ok) + 32'(data_req && !data_addr_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_q <= '0;
      perf_data_q <= '0;
      perf_wait_q <= '0;
    end else begin
      if (inst_data_ok) perf_inst_q <= perf_inst_q + 32'd1;
      if (data_data_ok) perf_data_q <= perf_data_q + 32'd1;
      perf_wait_q <= perf_wait_q + wait_inc;
    end
  end

  assign perf_inst_cnt = perf_inst_q;
  assign perf_data_cnt = perf_data_q;
  assign perf_wait_cnt = perf_wait_q;
`endif

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like slave bus between the instruction-fetch master (inst_*) and the memory-stage master (data_*).
- Sits between the pipeline and the single external/AXI-bridge port.
- One transaction in flight at a time. Data master has priority, with a starvation guard that protects fetch.
- Request command is registered at grant, so masters may change inputs after their addr_ok.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive data grants allowed while inst_req is pending before inst is forced to win (range 1..15)

Ports:
- clk  input  1  clock
- rst  input  1  reset
- inst_req  input  1  fetch request
- inst_wr  input  1  fetch write (normally 0)
- inst_size  input  2  0=byte, 1=half, 2=word
- inst_addr  input  ADDR_W  fetch address
- inst_wdata  input  DATA_W  fetch write data
- inst_addr_ok  output  1  fetch command accepted
- inst_data_ok  output  1  fetch transaction complete
- inst_rdata  output  DATA_W  fetch read data
- data_req, data_wr, data_size, data_addr, data_wdata  input  1/1/2/ADDR_W/DATA_W  memory-stage command
- data_addr_ok, data_data_ok  output  1/1  memory-stage handshake
- data_rdata  output  DATA_W  memory-stage read data
- s_req, s_wr  output  1/1  slave command
- s_size  output  2  slave size
- s_addr  output  ADDR_W  slave address
- s_wdata  output  DATA_W  slave write data
- s_rdata  input  DATA_W  slave read data
- s_addr_ok, s_data_ok  input  1/1  slave handshake
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset is synchronous, active-high, on rst; clock is clk.
- On reset: state=IDLE; owner=0 (inst); command registers=0; starve_cnt=0. All outputs are 0 during and after reset until a request arrives.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any req is high, pick a winner; assert <winner>_addr_ok combinationally in the same cycle; capture wr/size/addr/wdata into registers; record owner; go to ADDR next cycle.
  - Winner rule: data wins when both request, unless starve_cnt==STARVE_MAX, in which case inst wins.
  - A master's request counts as accepted only in the cycle req && addr_ok.
- ADDR:
  - s_req=1; s_wr/s_size/s_addr/s_wdata driven from the registers.
  - On s_addr_ok go to DATA. While s_addr_ok is low, stay and hold all slave outputs stable.
- DATA:
  - s_req=0.
  - On s_data_ok: owner's data_ok=1 for exactly that cycle and owner's rdata=s_rdata (combinational pass-through); go to IDLE next cycle.
  - The non-owner's data_ok is never asserted.
- s_data_ok is legal only in DATA. If seen in ADDR or IDLE it is ignored.
- rdata of the non-owner is 0. For writes, rdata is still s_rdata; masters ignore it.
- Back-to-back cost: one cycle (the IDLE grant cycle) between transactions. Minimum transaction length is 3 cycles: grant, addr, data.
- Starvation counter:
  - At each grant to data while inst_req=1, starve_cnt increments, saturating at STARVE_MAX.
  - Any grant to inst, or a grant cycle with inst_req=0, clears starve_cnt.
- Simultaneous events: a master that drops req in the grant cycle is not considered. Both req arriving in the same cycle follow the winner rule.
- Reset mid-transaction: immediately returns to IDLE and drops s_req, with no data_ok to either master. The slave shares rst and discards its in-flight work.
- busy=1 in ADDR and DATA.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Enabled: adds outputs perf_inst_cnt[31:0], perf_data_cnt[31:0], perf_wait_cnt[31:0].
  - perf_inst_cnt and perf_data_cnt increment on each completed transaction (owner data_ok).
  - perf_wait_cnt increments on every cycle a master's req is high without its addr_ok.
  - All three wrap at 2^32 and are cleared by rst.
- Disabled: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single inst read: inst_req=1, inst_addr=0xBFC00000, slave addr_ok 1 cycle after s_req, data_ok 2 cycles later with 0x24080001 -> inst_addr_ok in cycle 0, s_addr=0xBFC00000 in cycle 1, inst_data_ok=1 with inst_rdata=0x24080001 in exactly one cycle, data_data_ok never high.
- Collision: inst_req and data_req both high in the same IDLE cycle, data is sw 0x12345678 @0x80001000 size=2 -> data granted first (s_wr=1, s_wdata=0x12345678); inst granted in the IDLE cycle after data_data_ok.
- Starvation, STARVE_MAX=4: inst_req held high while data_req is re-asserted continuously -> data wins 4 grants, the 5th grant goes to inst, then starve_cnt=0.
- Slave stall: s_addr_ok held low 10 cycles -> s_req, s_addr and s_size are stable for all 10 cycles; changing data_addr after data_addr_ok does not change s_addr.
- Reset mid-DATA: rst=1 for one cycle while in DATA -> next cycle state=IDLE, s_req=0, busy=0; no data_ok pulse is emitted; the next inst request completes normally.
- ARB_PERF_CNT_EN build: 3 inst and 2 data transactions with 1-cycle slave latency -> perf_inst_cnt=3, perf_data_cnt=2; perf_wait_cnt equals the summed req-without-addr_ok cycles computed by the bench.
